// File: rtl/scan_mux_pkg.sv
// Shared types for the scan_mux word selector: mode encodings and controller states.
package scan_mux_pkg;

  localparam logic ModeManual = 1'b0;
  localparam logic ModeScan   = 1'b1;

  typedef enum logic [1:0] {
    StManual   = 2'd0,
    StScanWait = 2'd1,
    StScanHold = 2'd2
  } state_e;

endpackage

// File: rtl/scan_mux_slice.sv
// Combinational N:1 W-bit word selector; out-of-range indices yield zero.
module mux_slice #(
  parameter int unsigned N         = 8,
  parameter int unsigned W         = 4,
  parameter int unsigned SEL_W     = 3,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic [N*W-1:0] data_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [W-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o = MSB_FIRST ? data_i[(N-1-k)*W +: W] : data_i[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/scan_mux.sv
// Registered N:1 word selector with manual or round-robin auto-scan channel choice
// and a valid/ready output handshake.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned W         = 4,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned DWELL     = 3,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   i,
  input  logic [SEL_W-1:0] s,
  input  logic             mode,
  input  logic             z_ready,
  output logic [W-1:0]     z,
  output logic             z_valid,
  output logic [SEL_W-1:0] ch
);

  localparam int unsigned DwW = $clog2(DWELL) + 1;

  state_e           state_q;
  logic [SEL_W-1:0] scan_q;
  logic [DwW-1:0]   dwell_q;
  logic [W-1:0]     z_q;
  logic             z_valid_q;
  logic [SEL_W-1:0] ch_q;

  logic             slot_free;
  logic             dwell_done;
  logic             capture;
  logic [SEL_W-1:0] sel;
  logic [W-1:0]     slice;
  logic [SEL_W-1:0] scan_next;

  assign slot_free  = !z_valid_q || z_ready;
  assign dwell_done = (dwell_q == DwW'(DWELL - 1));
  assign sel        = (state_q == StManual) ? s : scan_q;
  assign scan_next  = (scan_q == SEL_W'(N - 1)) ? '0 : scan_q + 1'b1;

  // A mode change takes priority over any capture in the same cycle.
  always_comb begin
    capture = 1'b0;
    case (state_q)
      StManual:   capture = slot_free && (mode == ModeManual);
      StScanWait: capture = slot_free && (mode == ModeScan) && dwell_done;
      StScanHold: capture = slot_free && (mode == ModeScan);
      default:    capture = 1'b0;
    endcase
  end

  mux_slice #(
    .N        (N),
    .W        (W),
    .SEL_W    (SEL_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_mux_slice (
    .data_i(i),
    .sel_i (sel),
    .data_o(slice)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StManual;
      scan_q    <= '0;
      dwell_q   <= '0;
      z_q       <= '0;
      z_valid_q <= 1'b0;
      ch_q      <= '0;
    end else begin
      if (capture) begin
        z_q       <= slice;
        ch_q      <= sel;
        z_valid_q <= 1'b1;
      end else if (z_ready) begin
        z_valid_q <= 1'b0;
      end

      case (state_q)
        StManual: begin
          if (mode == ModeScan) begin
            state_q <= StScanWait;
            scan_q  <= '0;
            dwell_q <= '0;
          end
        end
        StScanWait, StScanHold: begin
          if (mode == ModeManual) begin
            state_q <= StManual;
            scan_q  <= '0;
            dwell_q <= '0;
          end else if (capture) begin
            state_q <= StScanWait;
            scan_q  <= scan_next;
            dwell_q <= '0;
          end else if (state_q == StScanWait) begin
            if (dwell_done) begin
              state_q <= StScanHold;
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
        end
        default: state_q <= StManual;
      endcase
    end
  end

  assign z       = z_q;
  assign z_valid = z_valid_q;
  assign ch      = ch_q;

endmodule
